qvalue_sequencer: RTL and testbench

Controller that sequences one Q-value inference through the final hidden layer and the output linear layer. It launches the hidden layer and membrane buffer, sums the per-timestep membrane vectors from the buffer into one vector, and then time-shares a single signed MAC over all actions × neurons against an external weight memory. Unnormalised Q-values (Σ over timesteps) are returned on a valid/ready handshake. Bias add and scaling happen downstream.

---
 rtl/snn_ctrl_pkg.sv | 22 ++
 rtl/signed_mac.sv | 50 +++++
 rtl/qvalue_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_qvalue_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// Shared controller definitions for the SNN inference sequencers.
// Holds the sequencer state encoding, the buffer timestep width and the
// helper that sizes accumulators for lossless summation.
package snn_ctrl_pkg;

  localparam int unsigned TIMESTEP_WIDTH = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ACCUM  = 3'd2,
    MAC    = 3'd3,
    RESULT = 3'd4
  } state_t;

  // Width needed to add `terms` values of `base_width` bits without overflow.
  function automatic int unsigned grow_width(input int unsigned base_width,
                                             input int unsigned terms);
    return base_width + $clog2(terms);
  endfunction

endpackage

// File: rtl/signed_mac.sv
// Registered signed multiply-accumulate with clear.
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset (clears accumulator)
//   en            - add (or load, with clr) a_in*b_in this cycle
//   clr           - with en: load the product; without en: zero the accumulator
//   a_in, b_in    - signed operands
//   acc_nxt_c     - value the accumulator takes at the next edge, so callers
//                   can snapshot a finished sum without an extra cycle
module signed_mac #(
  parameter int unsigned A_WIDTH   = 16,
  parameter int unsigned B_WIDTH   = 16,
  parameter int unsigned ACC_WIDTH = 40
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic                        clr,
  input  logic signed [A_WIDTH-1:0]   a_in,
  input  logic signed [B_WIDTH-1:0]   b_in,
  output logic signed [ACC_WIDTH-1:0] acc_nxt_c
);

  localparam int unsigned PROD_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [PROD_WIDTH-1:0] prod_c;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  acc_d;

  // Full-precision product, sign-extended into the accumulator.
  always_comb begin
    prod_c = PROD_WIDTH'(a_in) * PROD_WIDTH'(b_in);
    acc_d  = acc_q;
    if (en) begin
      acc_d = clr ? ACC_WIDTH'(prod_c) : acc_q + ACC_WIDTH'(prod_c);
    end else if (clr) begin
      acc_d = '0;
    end
  end

  assign acc_nxt_c = acc_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/qvalue_sequencer.sv
// Sequences one Q-value inference: launches the hidden layer, sums the
// per-timestep membrane vectors, then time-shares one signed MAC over all
// actions x neurons against an external weight memory.
// Ports:
//   clk, reset_n                 - clock, synchronous active-low reset
//   req_valid/req_ready          - inference request handshake
//   layer_start                  - one-cycle start to hidden layer + buffer
//   membranes_in, timestep_in,
//   timestep_ready, buf_done     - membrane buffer stream
//   w_rd_en, w_addr, w_data      - weight memory, data one cycle after strobe
//   q_valid/q_ready, q_out       - unnormalised Q-value result handshake
//   busy, err                    - not idle; sticky protocol error
module qvalue_sequencer
  import snn_ctrl_pkg::*;
#(
  parameter int unsigned NUM_NEURONS    = 16,
  parameter int unsigned NUM_TIMESTEPS  = 30,
  parameter int unsigned NUM_ACTIONS    = 2,
  parameter int unsigned MEMBRANE_WIDTH = 24,
  parameter int unsigned WEIGHT_WIDTH   = 16,
  parameter int unsigned SUM_WIDTH      = grow_width(MEMBRANE_WIDTH, NUM_TIMESTEPS),
  parameter int unsigned ACC_WIDTH      = grow_width(SUM_WIDTH + WEIGHT_WIDTH, NUM_NEURONS),
  parameter int unsigned ADDR_WIDTH     = $clog2(NUM_ACTIONS * NUM_NEURONS)
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic                                        req_valid,
  output logic                                        req_ready,
  output logic                                        layer_start,
  input  logic [NUM_NEURONS-1:0][MEMBRANE_WIDTH-1:0]  membranes_in,
  input  logic [TIMESTEP_WIDTH-1:0]                   timestep_in,
  input  logic                                        timestep_ready,
  input  logic                                        buf_done,
  output logic                                        w_rd_en,
  output logic [ADDR_WIDTH-1:0]                       w_addr,
  input  logic signed [WEIGHT_WIDTH-1:0]              w_data,
  output logic                                        q_valid,
  input  logic                                        q_ready,
  output logic [NUM_ACTIONS-1:0][ACC_WIDTH-1:0]       q_out,
  output logic                                        busy,
  output logic                                        err
);

  localparam int unsigned NIDX_WIDTH = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned AIDX_WIDTH = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1;
  localparam logic [NIDX_WIDTH-1:0]     LAST_N = NIDX_WIDTH'(NUM_NEURONS - 1);
  localparam logic [AIDX_WIDTH-1:0]     LAST_A = AIDX_WIDTH'(NUM_ACTIONS - 1);
  localparam logic [TIMESTEP_WIDTH-1:0] T_MAX  = TIMESTEP_WIDTH'(NUM_TIMESTEPS);

  state_t                          state_q, state_d;
  logic [TIMESTEP_WIDTH-1:0]       count_q, count_d;
  logic signed [SUM_WIDTH-1:0]     sum_q [NUM_NEURONS];
  logic signed [SUM_WIDTH-1:0]     sum_d [NUM_NEURONS];
  logic [NIDX_WIDTH-1:0]           n_q, n_d;
  logic [AIDX_WIDTH-1:0]           a_q, a_d;
  logic                            pend_vld_q, pend_vld_d;
  logic [NIDX_WIDTH-1:0]           pend_n_q, pend_n_d;
  logic [AIDX_WIDTH-1:0]           pend_a_q, pend_a_d;
  logic                            req_ready_q, req_ready_d;
  logic                            layer_start_q, layer_start_d;
  logic                            w_rd_en_q, w_rd_en_d;
  logic [ADDR_WIDTH-1:0]           w_addr_q, w_addr_d;
  logic                            q_valid_q, q_valid_d;
  logic                            busy_q, busy_d;
  logic                            err_q, err_d;
  logic [NUM_ACTIONS-1:0][ACC_WIDTH-1:0] q_out_q, q_out_d;

  logic                            accept_c;
  logic                            mac_en_c;
  logic                            mac_clr_c;
  logic signed [ACC_WIDTH-1:0]     mac_acc_nxt_c;

  assign accept_c  = (state_q == IDLE) && req_valid && req_ready_q;
  // Weight returned this cycle belongs to the address issued last cycle.
  assign mac_en_c  = (state_q == MAC) && pend_vld_q;
  assign mac_clr_c = accept_c || (mac_en_c && (pend_n_q == '0));

  signed_mac #(
    .A_WIDTH   (SUM_WIDTH),
    .B_WIDTH   (WEIGHT_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (mac_en_c),
    .clr       (mac_clr_c),
    .a_in      (sum_q[pend_n_q]),
    .b_in      (w_data),
    .acc_nxt_c (mac_acc_nxt_c)
  );

  // Snapshot each action's total as its last product lands.
  always_comb begin
    q_out_d = q_out_q;
    if (mac_en_c && (pend_n_q == LAST_N)) begin
      q_out_d[pend_a_q] = mac_acc_nxt_c;
    end
  end

  // Next-state, summer, address counters and registered outputs.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sum_d      = sum_q;
    n_d        = n_q;
    a_d        = a_q;
    err_d      = err_q;
    w_rd_en_d  = 1'b0;
    pend_vld_d = w_rd_en_q;
    pend_n_d   = n_q;
    pend_a_d   = a_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = LAUNCH;
          count_d = '0;
          err_d   = 1'b0;
          for (int n = 0; n < NUM_NEURONS; n++) sum_d[n] = '0;
        end
      end
      LAUNCH: state_d = ACCUM;
      ACCUM: begin
        if (timestep_ready && (count_q < T_MAX)) begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            sum_d[n] = sum_q[n] + SUM_WIDTH'($signed(membranes_in[n]));
          end
          count_d = count_q + TIMESTEP_WIDTH'(1);
          if (timestep_in != count_q) err_d = 1'b1;
        end
        // A short buffer run is flagged but the partial sums are still used.
        if (buf_done) begin
          state_d   = MAC;
          a_d       = '0;
          n_d       = '0;
          w_rd_en_d = 1'b1;
          if (count_d < T_MAX) err_d = 1'b1;
        end
      end
      MAC: begin
        if (w_rd_en_q) begin
          if (n_q != LAST_N) begin
            n_d       = n_q + NIDX_WIDTH'(1);
            w_rd_en_d = 1'b1;
          end else if (a_q != LAST_A) begin
            a_d       = a_q + AIDX_WIDTH'(1);
            n_d       = '0;
            w_rd_en_d = 1'b1;
          end
        end else begin
          // Drain cycle: the last product is absorbed this cycle.
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (q_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_ready_d   = (state_d == IDLE);
    layer_start_d = (state_d == LAUNCH);
    busy_d        = (state_d != IDLE);
    q_valid_d     = (state_d == RESULT);
    w_addr_d      = ADDR_WIDTH'(int'(a_d) * int'(NUM_NEURONS) + int'(n_d));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) sum_q[n] <= '0;
      n_q           <= '0;
      a_q           <= '0;
      pend_vld_q    <= 1'b0;
      pend_n_q      <= '0;
      pend_a_q      <= '0;
      req_ready_q   <= 1'b0;
      layer_start_q <= 1'b0;
      w_rd_en_q     <= 1'b0;
      w_addr_q      <= '0;
      q_valid_q     <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      q_out_q       <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      sum_q         <= sum_d;
      n_q           <= n_d;
      a_q           <= a_d;
      pend_vld_q    <= pend_vld_d;
      pend_n_q      <= pend_n_d;
      pend_a_q      <= pend_a_d;
      req_ready_q   <= req_ready_d;
      layer_start_q <= layer_start_d;
      w_rd_en_q     <= w_rd_en_d;
      w_addr_q      <= w_addr_d;
      q_valid_q     <= q_valid_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      q_out_q       <= q_out_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign layer_start = layer_start_q;
  assign w_rd_en     = w_rd_en_q;
  assign w_addr      = w_addr_q;
  assign q_valid     = q_valid_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign q_out       = q_out_q;

endmodule

// File: tb/tb_qvalue_sequencer.sv
// Self-checking bench for qvalue_sequencer: N=4, T=3, A=2, weights 1..8.
module tb_qvalue_sequencer;

  localparam int unsigned N   = 4;
  localparam int unsigned T   = 3;
  localparam int unsigned A   = 2;
  localparam int unsigned MW  = 24;
  localparam int unsigned WW  = 16;
  localparam int unsigned SW  = MW + $clog2(T);
  localparam int unsigned AW  = SW + WW + $clog2(N);
  localparam int unsigned ADW = $clog2(A * N);

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     req_valid = 1'b0;
  logic                     req_ready;
  logic                     layer_start;
  logic [N-1:0][MW-1:0]     membranes_in = '0;
  logic [4:0]               timestep_in = '0;
  logic                     timestep_ready = 1'b0;
  logic                     buf_done = 1'b0;
  logic                     w_rd_en;
  logic [ADW-1:0]           w_addr;
  logic signed [WW-1:0]     w_data = '0;
  logic                     q_valid;
  logic                     q_ready = 1'b0;
  logic [A-1:0][AW-1:0]     q_out;
  logic                     busy;
  logic                     err;

  always #5 clk = ~clk;

  qvalue_sequencer #(
    .NUM_NEURONS    (N),
    .NUM_TIMESTEPS  (T),
    .NUM_ACTIONS    (A),
    .MEMBRANE_WIDTH (MW),
    .WEIGHT_WIDTH   (WW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .layer_start    (layer_start),
    .membranes_in   (membranes_in),
    .timestep_in    (timestep_in),
    .timestep_ready (timestep_ready),
    .buf_done       (buf_done),
    .w_rd_en        (w_rd_en),
    .w_addr         (w_addr),
    .w_data         (w_data),
    .q_valid        (q_valid),
    .q_ready        (q_ready),
    .q_out          (q_out),
    .busy           (busy),
    .err            (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Weight memory: value = address + 1; read data one cycle after the strobe,
  // garbage otherwise so a mistimed capture shows up.
  longint         wmem [A*N];
  logic           pend = 1'b0;
  logic [ADW-1:0] pend_addr = '0;
  always @(negedge clk) begin
    w_data    = pend ? WW'(wmem[pend_addr]) : WW'(23130);
    pend      = w_rd_en;
    pend_addr = w_addr;
  end

  // Model: stimulus vectors, resulting sums, Q-values and error flag.
  longint vecs [T][N];
  int     ts_seq [T];
  longint msum [N];
  longint exp_q [A];
  longint got_q [A];
  logic   exp_err;
  logic   got_err;
  bit     mon_en = 1'b0;
  int     rd_idx = 0;

  // Per-cycle compare: address sequence and result payload.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (!busy) rd_idx = 0;
      if (w_rd_en) begin
        chk("w_addr_seq", longint'(w_addr), longint'(rd_idx));
        rd_idx++;
      end
      if (q_valid) begin
        for (int a = 0; a < A; a++) chk("q_out", $signed(q_out[a]), exp_q[a]);
        chk("err_at_result", longint'(err), longint'(exp_err));
        chk("busy_at_result", longint'(busy), 1);
        chk("req_ready_at_result", longint'(req_ready), 0);
      end
    end
  end

  task automatic build_model(input int nsteps);
    exp_err = 1'b0;
    for (int n = 0; n < N; n++) msum[n] = 0;
    for (int t = 0; t < nsteps; t++) begin
      for (int n = 0; n < N; n++) msum[n] += vecs[t][n];
      if (ts_seq[t] != t) exp_err = 1'b1;
    end
    if (nsteps < T) exp_err = 1'b1;
    for (int a = 0; a < A; a++) begin
      exp_q[a] = 0;
      for (int n = 0; n < N; n++) exp_q[a] += wmem[a*N + n] * msum[n];
    end
  endtask

  task automatic set_uniform(input longint v);
    for (int t = 0; t < T; t++) begin
      ts_seq[t] = t;
      for (int n = 0; n < N; n++) vecs[t][n] = v;
    end
  endtask

  // One inference; abort_at >= 0 pulses reset that many cycles into MAC.
  task automatic run_inference(input int nsteps, input int hold, input int abort_at);
    int cyc;
    build_model(nsteps);
    for (int a = 0; a < A; a++) got_q[a] = -1;
    got_err = 1'bx;
    cyc = 0;
    while (!req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("req_ready_idle", longint'(req_ready), 1);
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("layer_start_hi", longint'(layer_start), 1);
    chk("busy_after_req", longint'(busy), 1);
    chk("req_ready_busy", longint'(req_ready), 0);
    chk("err_cleared", longint'(err), 0);
    @(negedge clk);
    chk("layer_start_pulse", longint'(layer_start), 0);
    for (int t = 0; t < nsteps; t++) begin
      timestep_ready = 1'b1;
      timestep_in    = 5'(ts_seq[t]);
      for (int n = 0; n < N; n++) membranes_in[n] = MW'(vecs[t][n]);
      @(negedge clk);
    end
    timestep_ready = 1'b0;
    membranes_in   = '0;
    buf_done       = 1'b1;
    @(negedge clk);
    buf_done = 1'b0;
    chk("w_rd_en_mac_entry", longint'(w_rd_en), 1);
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("abort_w_rd_en", longint'(w_rd_en), 0);
      chk("abort_q_valid", longint'(q_valid), 0);
      chk("abort_busy", longint'(busy), 0);
      chk("abort_err", longint'(err), 0);
      chk("abort_layer_start", longint'(layer_start), 0);
      chk("abort_req_ready_in_reset", longint'(req_ready), 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("abort_req_ready_after", longint'(req_ready), 1);
      chk("abort_q_out0", $signed(q_out[0]), 0);
      return;
    end
    cyc = 0;
    while (!q_valid && cyc < 40) begin @(negedge clk); cyc++; end
    chk("q_valid_latency", longint'(cyc), longint'(A*N + 1));
    for (int a = 0; a < A; a++) got_q[a] = $signed(q_out[a]);
    got_err = err;
    for (int h = 0; h < hold; h++) begin
      chk("q_valid_held", longint'(q_valid), 1);
      for (int a = 0; a < A; a++) chk("q_out_stable", $signed(q_out[a]), got_q[a]);
      @(negedge clk);
    end
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
    chk("q_valid_dropped", longint'(q_valid), 0);
    chk("req_ready_after_accept", longint'(req_ready), 1);
    chk("busy_after_accept", longint'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < A*N; i++) wmem[i] = i + 1;
    exp_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_q_valid", longint'(q_valid), 0);
    chk("rst_w_rd_en", longint'(w_rd_en), 0);
    chk("rst_layer_start", longint'(layer_start), 0);
    chk("rst_err", longint'(err), 0);
    chk("rst_q_out1", $signed(q_out[1]), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready_after", longint'(req_ready), 1);
    mon_en = 1'b1;

    // All ones.
    set_uniform(1);
    run_inference(T, 0, -1);
    chk("pin_s1_q0", got_q[0], 30);
    chk("pin_s1_q1", got_q[1], 78);
    chk("pin_s1_err", longint'(got_err), 0);

    // Neuron-dependent membranes, result held for 5 cycles.
    for (int t = 0; t < T; t++) begin
      ts_seq[t] = t;
      vecs[t][0] = -2; vecs[t][1] = 0; vecs[t][2] = 3; vecs[t][3] = 5;
    end
    run_inference(T, 5, -1);
    chk("pin_s2_q0", got_q[0], 81);
    chk("pin_s2_q1", got_q[1], 153);

    // timestep_ready outside ACCUM is ignored.
    timestep_ready = 1'b1;
    timestep_in    = 5'd7;
    @(negedge clk);
    timestep_ready = 1'b0;
    @(negedge clk);
    chk("idle_ts_pulse_err", longint'(err), 0);
    chk("idle_ts_pulse_busy", longint'(busy), 0);

    // Out-of-order timestep indices.
    set_uniform(1);
    ts_seq[1] = 2;
    run_inference(T, 1, -1);
    chk("pin_s3_err", longint'(got_err), 1);
    chk("pin_s3_q0", got_q[0], 30);

    // Next request clears err; most-negative membranes exercise sign extension.
    set_uniform(-8388608);
    run_inference(T, 0, -1);
    chk("pin_s4_err", longint'(got_err), 0);

    // Early buf_done: partial sums.
    set_uniform(1);
    run_inference(2, 0, -1);
    chk("pin_s5_q0", got_q[0], 20);
    chk("pin_s5_q1", got_q[1], 52);
    chk("pin_s5_err", longint'(got_err), 1);

    // Reset mid-MAC, then a fresh inference.
    set_uniform(1);
    run_inference(T, 0, 3);
    run_inference(T, 0, -1);
    chk("pin_s6_q0", got_q[0], 30);
    chk("pin_s6_q1", got_q[1], 78);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
